// File: rtl/enum_cast_checker.sv
// enum_cast_checker: two-stage streaming range check of raw values against legal enum encodings
module enum_cast_checker #(
  parameter int WIDTH = 4,
  parameter int NUM_VALUES = 2,
  parameter logic [NUM_VALUES*WIDTH-1:0] LEGAL_VALUES = {4'd3, 4'd1},
  parameter bit STRICT = 1,
  parameter int CNT_W = 8,
  localparam int IDX_W = NUM_VALUES > 1 ? $clog2(NUM_VALUES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [IDX_W-1:0] out_index,
  output logic             out_illegal,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_value,
  input  logic             clear_err
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_value;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             s2_free, drop, s1_adv, ev, fv_base;
  logic [CNT_W-1:0] cnt_base;
  // scan members high to low so the lowest matching index is the one kept
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_VALUES - 1; k >= 0; k--)
      if (s1_value == LEGAL_VALUES[k*WIDTH +: WIDTH]) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
  end
  assign s2_free  = !out_valid || out_ready;
  assign drop     = STRICT && !hit;
  assign s1_adv   = s1_valid && (drop || s2_free);
  assign in_ready = !rst && (!s1_valid || s1_adv);
  assign ev       = s1_adv && !hit;
  assign cnt_base = clear_err ? '0 : err_count;
  assign fv_base  = !clear_err && first_err_valid;
  // S1 captures a new input whenever it is empty or its occupant moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
    end else if (!s1_valid || s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_value <= in_value;
    end
  end
  // S2 takes the classified S1 value unless it is being discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_value   <= '0;
      out_index   <= '0;
      out_illegal <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid && !drop;
      if (s1_valid && !drop) begin
        out_value   <= s1_value;
        out_index   <= idx;
        out_illegal <= !hit;
      end
    end
  end
  // sticky error statistics; a same-cycle clear is applied before the new event
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_value <= '0;
    end else begin
      err_count       <= ev ? (&cnt_base ? cnt_base : cnt_base + 1'b1) : cnt_base;
      first_err_valid <= fv_base || ev;
      if (ev && !fv_base) first_err_value <= s1_value;
    end
  end
endmodule

// File: doc/enum_cast_checker.md
# enum_cast_checker

Streaming range checker for enum casts: validates raw integral values against a parametrised set of legal enum encodings, emits the matching ordinal, and flags or drops out-of-range values. Generalises the static out-of-range cast rule to a runtime, any-width, any-member-count block in the type-checking datapath. It sits between a producer of raw integers and any consumer that requires a legal enum value, and keeps sticky error statistics for debug readout.

## Interface
- WIDTH, 4: bit width of the enum base type and of data values.
- NUM_VALUES, 2: number of legal enum members, 1 or more.
- LEGAL_VALUES, {4'd3, 4'd1}: packed NUM_VALUES*WIDTH vector; member k occupies bits [k*WIDTH +: WIDTH]. The default is members 1 and 3.
- STRICT, 1: 1 drops illegal values; 0 forwards them with out_illegal set.
- CNT_W, 8: width of the error counter.
- Derived IDX_W = max(1, $clog2(NUM_VALUES)).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input value is offered.
- in_ready  out  1  block accepts the value this cycle.
- in_value  in  WIDTH  raw integral value.
- out_valid  out  1  result is offered.
- out_ready  in  1  consumer accepts the result.
- out_value  out  WIDTH  value, passed through unchanged.
- out_index  out  IDX_W  ordinal of the matching member; 0 when illegal.
- out_illegal  out  1  value matches no member. Only ever 1 when STRICT=0.
- err_count  out  CNT_W  saturating count of illegal values.
- first_err_valid  out  1  first_err_value holds a captured value.
- first_err_value  out  WIDTH  first illegal value seen since reset or clear.
- clear_err  in  1  one-cycle pulse that clears the error statistics.

## Operation
- Two-stage pipeline:
  - S1 registers the accepted input.
  - Classification is combinational on S1 contents.
  - S2 registers the value, index and illegal flag, and drives the out_* ports.
- Matching:
  - Equality compare of the value against every member.
  - With duplicate members, the lowest index wins.
  - No match means illegal.
- Stage advance:
  - S2 loads when it is empty or out_ready=1.
  - S1 advances into S2 under the same condition.
  - In STRICT mode an illegal S1 value is discarded instead and S1 always advances.
- in_ready = !rst && (S1 empty || S1 advancing). This is combinational, so full throughput is sustained with out_ready held at 1.
- Illegal event: an illegal value leaves S1, whether discarded or forwarded.
  - err_count increments by 1 per event and saturates at 2^CNT_W-1.
  - first_err_value captures the value and first_err_valid is set, only if first_err_valid was 0.
- clear_err:
  - Zeroes err_count and first_err_valid.
  - If an illegal event occurs in the same cycle, the clear is applied first and the event is then recorded: err_count=1 and the value is captured.
- Data is never reordered or duplicated. Legal values are never dropped.

## Timing
- Reset values:
  - out_valid=0, out_value=0, out_index=0, out_illegal=0.
  - err_count=0, first_err_valid=0, first_err_value=0.
  - S1 and S2 are empty.
  - in_ready=0 while rst=1 and 1 on the first cycle after reset.
- Latency:
  - A value accepted at edge N appears with out_valid=1 after edge N+1, provided there is no stall.
  - Minimum is 2 cycles from in_valid being sampled to out_valid.
- Output stability: while out_valid=1 and out_ready=0, all out_* ports hold stable.
- Backpressure: with out_ready=0, at most 2 values are buffered. Then in_ready=0 until out_ready returns.
- Reset mid-operation flushes both stages without any output handshake. Buffered illegal values are not counted.
- Error statistics update on the same edge the illegal value leaves S1. They are visible the next cycle.

## Test plan
- Defaults, stream 1, 3, 2, 0 with out_ready=1:
  - Outputs (1, idx 0), then (3, idx 1), back-to-back.
  - 2 and 0 are dropped.
  - err_count=2, first_err_value=2.
- STRICT=0, stream 2, 3:
  - Output (2, idx 0, illegal 1), then (3, idx 1, illegal 0).
  - err_count=1.
- out_ready=0 while streaming 1, 3, 1:
  - in_ready falls after two acceptances and the outputs hold.
  - After out_ready=1, the sequence 1, 3, 1 is delivered in order with nothing lost.
- CNT_W=2, stream six 0s: err_count sticks at 3 and first_err_value=0.
- clear_err pulsed in the same cycle as an illegal 2 leaves S1 (err_count previously 5): err_count=1, first_err_value=2, first_err_valid=1.
- WIDTH=8, NUM_VALUES=3, LEGAL_VALUES={8'd9, 8'd200, 8'd9}:
  - 9 gives idx 0.
  - 200 gives idx 1.
  - 10 is illegal.
  - Assert rst while both stages are full: out_valid=0 the next cycle and no count change.
